// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared types and constants for the load/store memory port.
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    // Bit positions inside rw_type = {u, w, h, b}
    localparam int RW_U = 3;
    localparam int RW_W = 2;
    localparam int RW_H = 1;
    localparam int RW_B = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    function automatic logic size_onehot(input logic [3:0] rw_type);
        return ($countones({rw_type[RW_W], rw_type[RW_H], rw_type[RW_B]}) == 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_mem_port_if.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_mem_port_if
//  Description : Word-aligned data bus between the LSU and data memory.
//  Revision    : 1.0 - initial release
// ============================================================================
interface lsu_mem_port_if;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_gnt, bus_rvalid, bus_rdata
    );

endinterface

`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_align
//  Description : Byte-lane steering: store enables/shift, load extract/extend.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
(
    input  wire logic [1:0]  i_off,
    input  wire logic [3:0]  i_rw_type,
    input  wire logic [31:0] i_wdata,
    input  wire logic [31:0] i_rdata,
    output logic      [3:0]  o_be,
    output logic      [31:0] o_wdata_sh,
    output logic             o_misalign,
    output logic      [31:0] o_rdata_ext
);

    logic [31:0] w_rdata_sh;
    logic        w_sext;

    always_comb begin
        o_be        = 4'b0000;
        o_wdata_sh  = i_wdata << {i_off, 3'b000};
        o_misalign  = (i_rw_type[RW_H] & i_off[0]) |
                      (i_rw_type[RW_W] & (i_off != 2'b00));
        w_rdata_sh  = i_rdata >> {i_off, 3'b000};
        w_sext      = ~i_rw_type[RW_U];
        o_rdata_ext = w_rdata_sh;

        if (i_rw_type[RW_B]) begin
            o_be        = 4'b0001 << i_off;
            o_rdata_ext = {{24{w_sext & w_rdata_sh[7]}}, w_rdata_sh[7:0]};
        end else if (i_rw_type[RW_H]) begin
            o_be        = 4'b0011 << i_off;
            o_rdata_ext = {{16{w_sext & w_rdata_sh[15]}}, w_rdata_sh[15:0]};
        end else if (i_rw_type[RW_W]) begin
            // Aligned word: offset is zero, so the shifted value is the raw word
            o_be        = 4'b1111;
        end
    end

endmodule

`default_nettype wire

// File: rtl/lsu_mem_port.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_mem_port
//  Description : Load/store unit front end: one access in flight on the bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        req_valid,
    output logic             req_ready,
    input  wire logic        mem_wen,
    input  wire logic        mem_ren,
    input  wire logic [3:0]  rw_type,
    input  wire logic [31:0] addr,
    input  wire logic [31:0] wdata,
    input  wire logic [4:0]  rd_in,
    lsu_mem_port_if.master   bus,
    output logic             resp_valid,
    output logic      [31:0] resp_rdata,
    output logic      [4:0]  resp_rd,
    output logic             err_valid,
    output logic      [1:0]  err_code
);

    lsu_state_t  r_state;
    lsu_state_t  w_state_next;

    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic        r_we;
    logic [3:0]  r_type;
    logic [4:0]  r_rd;
    logic [31:0] r_rdata;
    logic [TO_W-1:0] r_cnt;
    logic        r_err_valid;
    logic [1:0]  r_err_code;

    logic        w_accept;
    logic        w_illegal;
    logic        w_timeout;
    logic        w_err_set;
    logic [1:0]  w_err_code;
    logic [1:0]  w_off;
    logic [3:0]  w_type;
    logic [3:0]  w_be;
    logic [31:0] w_wdata_sh;
    logic        w_misalign;
    logic [31:0] w_ld_data;

    assign w_accept  = (r_state == ST_IDLE) & req_valid & (mem_wen | mem_ren);
    assign w_illegal = (mem_wen & mem_ren) | ~size_onehot(rw_type) |
                       (rw_type[RW_U] & (rw_type[RW_W] | mem_wen));
    // Error pulse lands TIMEOUT_CYCLES cycles after the gnt cycle
    assign w_timeout = (r_cnt == TO_W'(TIMEOUT_CYCLES - 2));

    // Incoming access is steered while idle, the held one afterwards
    assign w_off  = (r_state == ST_IDLE) ? addr[1:0] : r_addr[1:0];
    assign w_type = (r_state == ST_IDLE) ? rw_type   : r_type;

    lsu_align u_align (
        .i_off       (w_off),
        .i_rw_type   (w_type),
        .i_wdata     (wdata),
        .i_rdata     (bus.bus_rdata),
        .o_be        (w_be),
        .o_wdata_sh  (w_wdata_sh),
        .o_misalign  (w_misalign),
        .o_rdata_ext (w_ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_err_set    = 1'b0;
        w_err_code   = ERR_NONE;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_illegal) begin
                        w_err_set  = 1'b1;
                        w_err_code = ERR_ILLEGAL;
                    end else if (w_misalign) begin
                        w_err_set  = 1'b1;
                        w_err_code = ERR_MISALIGN;
                    end else begin
                        w_state_next = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (bus.bus_gnt) begin
                    w_state_next = r_we ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.bus_rvalid) begin
                    w_state_next = ST_DONE;
                end else if (w_timeout) begin
                    w_state_next = ST_IDLE;
                    w_err_set    = 1'b1;
                    w_err_code   = ERR_TIMEOUT;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= '0;
            r_be        <= '0;
            r_wdata     <= '0;
            r_we        <= 1'b0;
            r_type      <= '0;
            r_rd        <= '0;
            r_rdata     <= '0;
            r_cnt       <= '0;
            r_err_valid <= 1'b0;
            r_err_code  <= ERR_NONE;
        end else begin
            r_err_valid <= w_err_set;
            r_err_code  <= w_err_code;
            if ((r_state == ST_IDLE) && (w_state_next == ST_REQ)) begin
                r_addr  <= addr;
                r_be    <= w_be;
                r_wdata <= w_wdata_sh;
                r_we    <= mem_wen;
                r_type  <= rw_type;
                r_rd    <= mem_wen ? 5'd0 : rd_in;
                r_rdata <= '0;
            end
            if ((r_state == ST_REQ) && bus.bus_gnt) begin
                r_cnt <= '0;
            end
            if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt + TO_W'(1);
                if (bus.bus_rvalid) begin
                    r_rdata <= w_ld_data;
                end
            end
        end
    end

    always_comb begin
        req_ready      = (r_state == ST_IDLE);
        bus.bus_req    = 1'b0;
        bus.bus_we     = 1'b0;
        bus.bus_addr   = '0;
        bus.bus_be     = '0;
        bus.bus_wdata  = '0;
        resp_valid     = 1'b0;
        resp_rdata     = '0;
        resp_rd        = '0;
        err_valid      = r_err_valid;
        err_code       = r_err_code;
        if (r_state == ST_REQ) begin
            bus.bus_req   = 1'b1;
            bus.bus_we    = r_we;
            bus.bus_addr  = {r_addr[31:2], 2'b00};
            bus.bus_be    = r_be;
            bus.bus_wdata = r_wdata;
        end
        if (r_state == ST_DONE) begin
            resp_valid = 1'b1;
            resp_rdata = r_rdata;
            resp_rd    = r_rd;
        end
    end

endmodule

`default_nettype wire
